// File: rtl/mem_burst_master.sv
// Burst initiator for the memory controller port: splits client burst commands
// into single-beat memory accesses and returns read data through a
// credit-limited response FIFO tagged with a last-beat flag.
module mem_burst_master #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int LEN_WIDTH    = 4,
   parameter int READ_LATENCY = 1,
   parameter int RSP_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic                  cmdWrite,
   input  logic [ADDR_WIDTH-1:0] cmdAddr,
   input  logic [LEN_WIDTH-1:0]  cmdLen,
   input  logic                  wrValid,
   output logic                  wrReady,
   input  logic [DATA_WIDTH-1:0] wrData,
   output logic                  rspValid,
   input  logic                  rspReady,
   output logic [DATA_WIDTH-1:0] rspData,
   output logic                  rspLast,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memDataIn,
   output logic                  memWriteEnable,
   input  logic [DATA_WIDTH-1:0] memDataOut,
   output logic                  busy
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(RSP_DEPTH);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                  state, state_nx;
   logic                    alive;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [LEN_WIDTH-1:0]    remaining;
   logic                    cmd_fire, wr_fire, issue, push, pop, credit;
   logic [READ_LATENCY-1:0] pipe_v, pipe_l;
   logic [CW-1:0]           inflight, occ;
   logic [PW:0]             wptr, rptr;
   logic [DATA_WIDTH-1:0]   fifo_d [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]    fifo_l;

   assign occ      = wptr - rptr;
   assign credit   = ({1'b0, occ} + {1'b0, inflight}) < DEPTH_C;
   assign push     = pipe_v[READ_LATENCY-1];
   assign rspValid = (occ != '0);
   assign pop      = rspValid && rspReady;
   assign rspData  = fifo_d[rptr[PW-1:0]];
   assign rspLast  = fifo_l[rptr[PW-1:0]];
   assign busy     = (state != IDLE) || (inflight != '0);

   // State register; alive keeps cmdReady low while reset is held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nx;
         alive <= 1'b1;
      end
   end

   // Next-state decode and handshake strobes
   always_comb begin
      state_nx = state;
      cmd_fire = 1'b0;
      wr_fire  = 1'b0;
      issue    = 1'b0;
      cmdReady = 1'b0;
      wrReady  = 1'b0;
      case (state)
         IDLE: begin
            cmdReady = alive;
            if (cmdValid && alive) begin
               cmd_fire = 1'b1;
               state_nx = cmdWrite ? WRITE : READ;
            end
         end
         WRITE: begin
            wrReady = 1'b1;
            if (wrValid) begin
               wr_fire = 1'b1;
               if (remaining == '0) state_nx = IDLE;
            end
         end
         READ: begin
            if (credit) begin
               issue = 1'b1;
               if (remaining == '0) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight == '0) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Burst address/count and registered memory port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr           <= '0;
         remaining      <= '0;
         memAddr        <= '0;
         memDataIn      <= '0;
         memWriteEnable <= 1'b0;
      end else begin
         memWriteEnable <= wr_fire;
         if (cmd_fire) begin
            addr      <= cmdAddr;
            remaining <= cmdLen;
         end else if (wr_fire || issue) begin
            memAddr   <= addr;
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
         end
         if (wr_fire) memDataIn <= wrData;
      end
   end

   // Read-latency pipe of issued beats and their in-flight count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v   <= '0;
         pipe_l   <= '0;
         inflight <= '0;
      end else begin
         pipe_v[0] <= issue;
         pipe_l[0] <= issue && (remaining == '0);
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
         inflight <= inflight + CW'(issue) - CW'(push);
      end
   end

   // Response FIFO storage and pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr   <= '0;
         rptr   <= '0;
         fifo_l <= '0;
         for (int unsigned i = 0; i < RSP_DEPTH; i++) fifo_d[i] <= '0;
      end else begin
         if (push) begin
            fifo_d[wptr[PW-1:0]] <= memDataOut;
            fifo_l[wptr[PW-1:0]] <= pipe_l[READ_LATENCY-1];
            wptr                 <= wptr + (PW+1)'(1);
         end
         if (pop) rptr <= rptr + (PW+1)'(1);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && (occ == FULL_C)));

endmodule
